fft_bitrev_loader: RTL and testbench
====================================

# fft_bitrev_loader

Input-side loader for the 32-point FFT datapath. It accepts one stream of complex samples over a valid/ready handshake and writes each sample into a 32-entry frame buffer at the bit-reversed index of its arrival position. The arrival position comes from a 5-bit mod-32 write counter. Once a frame is complete, it presents the buffer to the downstream butterfly stage for natural-order reads, and holds the frame until that stage releases it.

## Interface

Parameters:
- DATA_W, 32, sample width in bits (real in upper half, imaginary in lower half; opaque to this block)

Ports:
- clk  in  1  system clock; all logic on rising edge; one clock domain
- clr  in  1  synchronous, active-high reset
- en  in  1  global enable; when 0, all state, counter, memory and outputs hold; in_ready forced 0
- in_valid  in  1  upstream sample valid
- in_data  in  DATA_W  upstream sample
- in_last  in  1  marks the final (32nd) sample of a frame; qualified by in_valid
- in_ready  out  1  loader accepts a sample this cycle
- frame_ready  out  1  complete frame held in buffer, bit-reversed order
- rd_en  in  1  downstream read request
- rd_addr  in  5  downstream read address, natural order
- rd_data  out  DATA_W  buffer word, registered
- rd_valid  out  1  rd_data is valid this cycle
- frame_done  in  1  downstream releases the frame (single-cycle pulse)
- frame_err  out  1  one-cycle pulse on an in_last / count mismatch
- fill_count  out  5  samples accepted in the current frame (write counter value)

## Operation

- Two states: FILL and HOLD. Reset state is FILL.
- in_ready = (state == FILL) & en & ~clr, combinational. frame_ready = (state == HOLD), registered.
- Accept = in_valid & in_ready.
- On accept in FILL:
  - mem[bitrev5(fill_count)] <= in_data.
  - bitrev5(b4 b3 b2 b1 b0) = b0 b1 b2 b3 b4.
  - fill_count increments mod 32.
- Normal frame end: accept with fill_count == 31 and in_last == 1.
  - fill_count wraps to 0.
  - State goes to HOLD.
- Mismatch, either case below:
  - Cases: in_last == 1 with fill_count != 31, or fill_count == 31 with in_last == 0.
  - The sample is written.
  - frame_err pulses next cycle.
  - fill_count goes to 0 and state stays FILL. Partial frame discarded.
- HOLD:
  - in_ready = 0; input ignored.
  - rd_en = 1 gives rd_data <= mem[rd_addr] and rd_valid <= 1 next cycle.
  - rd_en = 0 gives rd_valid <= 0 and rd_data holds.
- frame_done in HOLD moves the state to FILL next cycle. A read issued in the same cycle still completes.
- frame_done in FILL is ignored. rd_en in FILL is ignored (rd_valid <= 0).
- Memory contents are not cleared by clr; only state, counter and outputs reset.

## Timing

- Reset values (cycle after clr sampled high): state FILL, fill_count 0, frame_ready 0, rd_valid 0, rd_data 0, frame_err 0.
- in_ready is 0 while clr is high and 1 on the first cycle after clr falls, provided en = 1.
- Write latency: a sample accepted at edge k is readable by an rd_en issued at or after edge k+1 in HOLD.
- frame_ready rises one cycle after the 32nd accept.
- Read latency: 1 cycle from rd_en to rd_valid/rd_data. One read per cycle, fully pipelined.
- A new accept is possible on the cycle after frame_done is sampled, since in_ready = 1 then.
- clr mid-fill or mid-hold aborts the frame with no frame_err. en = 0 freezes everything, including pending rd_valid and the frame_err pulse.
- clr has priority over en, and en has priority over all other inputs.

## Test plan

- Reset and basic frame:
  - Stimulus: clr for 2 cycles; feed in_data = index 0..31 back-to-back with in_last on index 31.
  - Required response: frame_ready = 1 exactly one cycle after the last accept; rd_addr 1 returns 16; rd_addr 6 returns 12; rd_addr 31 returns 31, each with rd_valid one cycle after rd_en.
- Backpressure and gaps:
  - Stimulus: toggle in_valid randomly and hold en = 0 for 5 cycles mid-frame.
  - Required response: fill_count advances only on accepts and stays frozen while en = 0; final buffer identical to the basic frame.
- Early in_last:
  - Stimulus: in_last on the 10th sample (fill_count 9).
  - Required response: frame_err pulses once; fill_count = 0; no frame_ready. The next clean 32-sample frame loads correctly.
- Missing in_last:
  - Stimulus: 32nd sample with in_last = 0.
  - Required response: frame_err pulses; state stays FILL.
- Hold and release:
  - Stimulus: in HOLD, drive in_valid = 1 for 10 cycles, then frame_done together with rd_en, rd_addr = 2.
  - Required response: in_ready = 0 throughout HOLD; the read returns 8; in_ready = 1 the next cycle; a new frame overwrites the buffer.
- Reset mid-operation:
  - Stimulus: clr at fill_count 20, then a full frame of value 100 + index.
  - Required response: frame_err = 0; reads return the new values only.

Source files
------------

// File: rtl/fft_bitrev_loader.sv
// Input-side loader for a 32-point FFT: writes each accepted sample at the
// bit-reversed index of its arrival position, then holds the frame for natural-order reads.
module fft_bitrev_loader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              frame_ready,
    input  logic              rd_en,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              frame_done,
    output logic              frame_err,
    output logic [4:0]        fill_count
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [4:0]        count_reg;
    logic [4:0]        count_next;
    logic [4:0]        wr_addr;
    logic              accept;
    logic              at_end;
    logic              frame_end;
    logic              mismatch;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              frame_err_reg;

    logic [DATA_W-1:0] mem [0:31];

    // Bit reversal is pure wiring: address bit gi comes from count bit 4-gi.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_bitrev
            assign wr_addr[gi] = count_reg[4-gi];
        end
    endgenerate

    assign accept    = in_valid & in_ready;
    assign at_end    = (count_reg == 5'd31);
    assign frame_end = accept & at_end & in_last;
    assign mismatch  = accept & (at_end ^ in_last);

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= FILL;
            count_reg <= 5'd0;
        end else if (en) begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            FILL: begin
                if (frame_end) begin
                    state_next = HOLD;
                    count_next = 5'd0;
                end else if (mismatch) begin
                    // Partial frame is abandoned; its samples stay in memory but are never presented.
                    count_next = 5'd0;
                end else if (accept) begin
                    count_next = count_reg + 5'd1;
                end
            end
            HOLD: begin
                if (frame_done) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Output logic
    always_comb begin
        in_ready    = (state_reg == FILL) & en & ~clr;
        frame_ready = (state_reg == HOLD);
    end

    // Frame buffer write port; contents deliberately survive clr.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= in_data;
        end
    end

    // Registered read port and status pulses, all frozen while en is low.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else if (en) begin
            frame_err_reg <= mismatch;
            if ((state_reg == HOLD) && rd_en) begin
                rd_data_reg  <= mem[rd_addr];
                rd_valid_reg <= 1'b1;
            end else begin
                rd_valid_reg <= 1'b0;
            end
        end
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign frame_err  = frame_err_reg;
    assign fill_count = count_reg;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed-plus-random bench for fft_bitrev_loader against a frame-level
// reference: sample number n of a frame is expected at buffer index reverse(n).
module tb_fft_bitrev_loader;

    logic        clk;
    logic        clr;
    logic        en;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        frame_ready;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        frame_done;
    logic        frame_err;
    logic [4:0]  fill_count;

    int errors = 0;
    int checks = 0;

    // Reference model: buffer image, position within current frame, hold flag.
    logic [31:0] model_mem [32];
    int          model_pos  = 0;
    bit          model_hold = 0;

    fft_bitrev_loader #(.DATA_W(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .en         (en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .frame_ready(frame_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rev5(input int v);
        int r = 0;
        for (int k = 0; k < 5; k++) begin
            r = r * 2 + ((v >> k) & 1);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample after an idle gap; update the model on acceptance and check status.
    task automatic send(input logic [31:0] d, input bit last, input int gap);
        bit got = 0;
        bit exp_err;
        int pos;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            pos = model_pos;
            model_mem[rev5(pos)] = d;
            exp_err = 1'b0;
            if (pos == 31 && last) begin
                model_hold = 1'b1;
                model_pos  = 0;
            end else if (pos == 31 || last) begin
                exp_err   = 1'b1;
                model_pos = 0;
            end else begin
                model_pos = pos + 1;
            end
            $display("tx write pos=%0d data=%0h last=%0d fill_count=%0d frame_err=%0d frame_ready=%0d",
                     pos, d, last, fill_count, frame_err, frame_ready);
            chk("fill_count", 32'(fill_count), 32'(model_pos));
            chk("frame_err", 32'(frame_err), 32'(exp_err));
            chk("frame_ready", 32'(frame_ready), 32'(model_hold));
        end
    endtask

    task automatic rd(input int a, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = 5'(a);
        tick();
        rd_en = 1'b0;
        $display("tx read addr=%0d data=%0h valid=%0d", a, rd_data, rd_valid);
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, exp);
    endtask

    task automatic release_frame();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        model_hold = 1'b0;
        chk("release_frame_ready", 32'(frame_ready), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        clr = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0; frame_done = 1'b0;

        // Reset
        tick();
        chk("in_ready_during_clr", 32'(in_ready), 32'd0);
        tick();
        chk("rst_fill_count", 32'(fill_count), 32'd0);
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        clr = 1'b0;
        #1;
        chk("in_ready_after_clr", 32'(in_ready), 32'd1);

        // Basic frame, data = index, back to back
        for (int i = 0; i < 32; i++) send(32'(i), i == 31, 0);
        rd(1, 32'd16);
        rd(6, 32'd12);
        rd(31, 32'd31);
        tick();
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);
        release_frame();

        // Backpressure gaps and a 5-cycle en freeze mid-frame
        for (int i = 0; i < 32; i++) begin
            if (i == 16) begin
                en = 1'b0;
                in_valid = 1'b1;
                in_data = 32'd16;
                for (int c = 0; c < 5; c++) begin
                    tick();
                    chk("freeze_fill_count", 32'(fill_count), 32'd16);
                    chk("freeze_in_ready", 32'(in_ready), 32'd0);
                end
                in_valid = 1'b0;
                en = 1'b1;
            end
            send(32'(i), i == 31, int'($urandom_range(0, 2)));
        end
        for (int a = 0; a < 32; a++) rd(a, model_mem[a]);
        rd(6, 32'd12);
        // en low freezes a pending rd_valid
        en = 1'b0;
        tick();
        chk("freeze_rd_valid", 32'(rd_valid), 32'd1);
        en = 1'b1;
        tick();
        chk("rd_valid_after_freeze", 32'(rd_valid), 32'd0);

        // Input ignored in HOLD, then release with a same-cycle read
        in_valid = 1'b1;
        in_data = 32'hdead;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_fill_count", 32'(fill_count), 32'd0);
        end
        in_valid = 1'b0;
        frame_done = 1'b1;
        rd_en = 1'b1;
        rd_addr = 5'd2;
        tick();
        frame_done = 1'b0;
        rd_en = 1'b0;
        model_hold = 1'b0;
        chk("release_rd_valid", 32'(rd_valid), 32'd1);
        chk("release_rd_data", rd_data, 32'd8);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_frame_ready", 32'(frame_ready), 32'd0);

        // Early in_last on the 10th sample, then a clean random frame
        for (int i = 0; i < 10; i++) send($urandom, i == 9, int'($urandom_range(0, 1)));
        tick();
        chk("err_pulse_end", 32'(frame_err), 32'd0);
        chk("early_no_frame_ready", 32'(frame_ready), 32'd0);
        for (int i = 0; i < 32; i++) send($urandom, i == 31, int'($urandom_range(0, 2)));
        for (int c = 0; c < 10; c++) begin
            int a = int'($urandom_range(0, 31));
            rd(a, model_mem[a]);
        end
        release_frame();

        // Missing in_last on the 32nd sample
        for (int i = 0; i < 32; i++) send($urandom, 1'b0, 0);
        tick();
        chk("missing_state_fill", 32'(in_ready), 32'd1);
        chk("missing_no_frame_ready", 32'(frame_ready), 32'd0);

        // clr at fill_count 20, then a fresh frame of 100 + index
        for (int i = 0; i < 20; i++) send($urandom, 1'b0, 0);
        chk("pre_clr_fill_count", 32'(fill_count), 32'd20);
        clr = 1'b1;
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        tick();
        clr = 1'b0;
        model_pos = 0;
        chk("clr_fill_count", 32'(fill_count), 32'd0);
        chk("clr_frame_err", 32'(frame_err), 32'd0);
        chk("clr_frame_ready", 32'(frame_ready), 32'd0);
        for (int i = 0; i < 32; i++) send(32'(100 + i), i == 31, int'($urandom_range(0, 1)));
        for (int a = 0; a < 32; a++) rd(a, model_mem[a]);
        rd(1, 32'd116);
        release_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
